// File: rtl/seq_pkg.sv
// Shared definitions for the serializer and the detector-side blocks it feeds:
// the two-state FSM encoding, the default idle line level and a counter-width helper.
package seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } seq_state_t;

  localparam logic IDLE_BIT_DEFAULT = 1'b1;

  // A 2-bit word still needs a 1-bit counter, so clamp $clog2 at 1
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/seq_serializer.sv
// Parallel-to-serial converter with a valid/ready load port. It emits one registered bit
// per clock and chains frames back to back when a new word is offered on the last bit.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x_out,
  output logic             busy,
  output logic             frame_done
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             at_last;
  logic             load;
  logic             advance;

  assign at_last    = (state == SHIFT) && (cnt == LAST_CNT);
  assign busy       = (state == SHIFT);
  assign frame_done = at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A word is only accepted when nothing is left of the current frame to shift out
  always_comb begin
    state_nxt = state;
    din_ready = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        din_ready = 1'b1;
        if (din_valid) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST_CNT) begin
          din_ready = 1'b1;
          if (din_valid) begin
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          advance = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The shift register holds the word already shifted so that its head bit is on x_out;
  // the next bit to present is therefore always the one just behind the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      shreg <= '0;
      x_out <= IDLE_BIT;
    end else if (load) begin
      cnt   <= '0;
      shreg <= din;
      x_out <= MSB_FIRST ? din[WIDTH-1] : din[0];
    end else if (advance) begin
      cnt   <= cnt + CW'(1);
      shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
      x_out <= MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
    end else begin
      cnt   <= '0;
      x_out <= IDLE_BIT;
    end
  end

endmodule
